// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Exception state is captured from the MEM stage; MFC0 reads are combinational with MTC0 bypass.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;
  localparam logic [4:0]  REG_CONFIG  = 5'd16;
  localparam logic [31:0] STATUS_RST  = 32'h10000000;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_int_q, timer_int_d;
  logic [31:0] fault_epc_s;

  // Software may only touch IV, WP and the two software interrupt bits of Cause.
  function automatic logic [31:0] cause_merge(input logic [31:0] old_v, input logic [31:0] wr_v);
    logic [31:0] res;
    res       = old_v;
    res[23:22] = wr_v[23:22];
    res[9:8]   = wr_v[9:8];
    return res;
  endfunction

  assign fault_epc_s = is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;

  // Next-state: timer and interrupt sampling, then MTC0, then exception overrides.
  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    timer_int_d = timer_int_q;
    cause_d[15:10] = int_i;

    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_int_d = 1'b1;
    end else begin
      timer_int_d = timer_int_q;
    end

    if (we_i) begin
      case (waddr_i)
        REG_COUNT:   count_d = data_i;
        REG_COMPARE: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;
        end
        REG_STATUS:  status_d = data_i;
        REG_EPC:     epc_d = data_i;
        REG_CAUSE:   cause_d = cause_merge(cause_d, data_i);
        default:     count_d = count_d;
      endcase
    end else begin
      count_d = count_d;
    end

    case (excepttype_i)
      32'h00000001: begin
        epc_d         = fault_epc_s;
        cause_d[31]   = is_in_delayslot_i;
        status_d[1]   = 1'b1;
        cause_d[6:2]  = 5'b00000;
      end
      32'h00000008, 32'h0000000a, 32'h0000000c, 32'h0000000d: begin
        // A nested exception keeps the EPC/BD of the outer one.
        if (status_q[1] == 1'b0) begin
          epc_d       = fault_epc_s;
          cause_d[31] = is_in_delayslot_i;
        end else begin
          epc_d = epc_d;
        end
        status_d[1]  = 1'b1;
        cause_d[6:2] = excepttype_i[4:0];
      end
      32'h0000000e: status_d[1] = 1'b0;
      default:      status_d = status_d;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      status_q    <= STATUS_RST;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      timer_int_q <= timer_int_d;
    end
  end

  // MFC0 read with bypass of the same-cycle MTC0 (exception updates are not bypassed).
  always_comb begin
    case (raddr_i)
      REG_COUNT:   data_o = count_q;
      REG_COMPARE: data_o = compare_q;
      REG_STATUS:  data_o = status_q;
      REG_CAUSE:   data_o = cause_q;
      REG_EPC:     data_o = epc_q;
      REG_PRID:    data_o = PRID_VALUE;
      REG_CONFIG:  data_o = CONFIG_VALUE;
      default:     data_o = 32'd0;
    endcase
    if (we_i && (waddr_i == raddr_i)) begin
      case (waddr_i)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: data_o = data_i;
        REG_CAUSE: data_o = cause_merge(cause_q, data_i);
        default:   data_o = data_o;
      endcase
    end else begin
      data_o = data_o;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign timer_int_o = timer_int_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_reg;

  logic        clk, rst, we_i, is_in_delayslot_i, timer_int_o;
  logic [4:0]  waddr_i, raddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_i, excepttype_i, current_inst_addr_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  localparam int S_COUNT = 0, S_COMPARE = 1, S_STATUS = 2, S_CAUSE = 3, S_EPC = 4,
                 S_TIMER = 5, S_DATA = 6, S_PRID = 7, S_CONFIG = 8;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string sel_name(input int s);
    case (s)
      S_COUNT:   return "count";
      S_COMPARE: return "compare";
      S_STATUS:  return "status";
      S_CAUSE:   return "cause";
      S_EPC:     return "epc";
      S_TIMER:   return "timer_int";
      S_DATA:    return "data_o";
      S_PRID:    return "prid";
      S_CONFIG:  return "config";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: DUT outputs are presented every cycle; compare all pending expectations.
  always @(negedge clk) begin
    while (expq.size() > 0) begin
      exp_t        it;
      logic [31:0] act;
      it = expq.pop_front();
      case (it.sel)
        S_COUNT:   act = count_o;
        S_COMPARE: act = compare_o;
        S_STATUS:  act = status_o;
        S_CAUSE:   act = cause_o;
        S_EPC:     act = epc_o;
        S_TIMER:   act = {31'd0, timer_int_o};
        S_DATA:    act = data_o;
        S_PRID:    act = prid_o;
        S_CONFIG:  act = config_o;
        default:   act = 32'hxxxxxxxx;
      endcase
      total = total + 1;
      if (act !== it.exp) begin
        bad = bad + 1;
        $display("FAIL %s at %0t: got %h expected %h", sel_name(it.sel), $time, act, it.exp);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v);
    exp_t it;
    it.sel = sel;
    it.exp = v;
    expq.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick(1);
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    excepttype_i = t; current_inst_addr_i = pc; is_in_delayslot_i = ds;
    tick(1);
    excepttype_i = 32'd0;
  endtask

  initial begin
    rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; data_i = 32'd0; raddr_i = 5'd0;
    int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0; is_in_delayslot_i = 1'b0;
    #1;
    expect_val(S_COUNT, 32'd0);
    expect_val(S_STATUS, 32'h10000000);
    expect_val(S_TIMER, 32'd0);
    expect_val(S_CONFIG, 32'h00008000);
    @(posedge clk); #1; rst = 1'b1;

    tick(5);
    expect_val(S_COUNT, 32'd5);
    expect_val(S_STATUS, 32'h10000000);
    expect_val(S_CAUSE, 32'd0);
    expect_val(S_TIMER, 32'd0);
    expect_val(S_PRID, 32'h004c0102);

    // Timer: Compare=20 written while count is 10.
    tick(5);
    expect_val(S_COUNT, 32'd10);
    mtc0(5'd11, 32'd20);
    expect_val(S_COMPARE, 32'd20);
    expect_val(S_TIMER, 32'd0);
    tick(9);
    expect_val(S_COUNT, 32'd20);
    expect_val(S_TIMER, 32'd0);
    tick(1);
    expect_val(S_TIMER, 32'd1);
    tick(3);
    expect_val(S_TIMER, 32'd1);
    mtc0(5'd11, 32'd100);
    expect_val(S_TIMER, 32'd0);
    expect_val(S_COMPARE, 32'd100);

    // Syscall in delay slot, nested syscall, ERET.
    exc(32'h8, 32'h100, 1'b1);
    expect_val(S_EPC, 32'hfc);
    expect_val(S_CAUSE, 32'h80000020);
    expect_val(S_STATUS, 32'h10000002);
    exc(32'h8, 32'h200, 1'b0);
    expect_val(S_EPC, 32'hfc);
    expect_val(S_CAUSE, 32'h80000020);
    exc(32'he, 32'h0, 1'b0);
    expect_val(S_STATUS, 32'h10000000);

    // Interrupt exception clears ExcCode and BD, then return.
    exc(32'h1, 32'h300, 1'b0);
    expect_val(S_EPC, 32'h300);
    expect_val(S_CAUSE, 32'h00000000);
    expect_val(S_STATUS, 32'h10000002);
    exc(32'he, 32'h0, 1'b0);

    // Cause write merges only writable bits; IP7..2 follow int_i.
    int_i = 6'b101010;
    mtc0(5'd13, 32'hffffffff);
    expect_val(S_CAUSE, 32'h00c0ab00);
    int_i = 6'b000000;
    tick(1);
    expect_val(S_CAUSE, 32'h00c00300);

    // Trap with EXL clear.
    exc(32'hd, 32'h400, 1'b0);
    expect_val(S_EPC, 32'h400);
    expect_val(S_CAUSE, 32'h00c00334);
    expect_val(S_STATUS, 32'h10000002);

    // Read bypass.
    we_i = 1'b1; waddr_i = 5'd14; raddr_i = 5'd14; data_i = 32'hdead0000;
    #1;
    expect_val(S_DATA, 32'hdead0000);
    expect_val(S_EPC, 32'h400);
    tick(1);
    expect_val(S_EPC, 32'hdead0000);
    waddr_i = 5'd13; raddr_i = 5'd13; data_i = 32'd0;
    #1;
    expect_val(S_DATA, 32'h00000034);
    tick(1);
    we_i = 1'b0; raddr_i = 5'd15;
    #1;
    expect_val(S_DATA, 32'h004c0102);
    expect_val(S_CAUSE, 32'h00000034);
    tick(1);
    raddr_i = 5'd3;
    #1;
    expect_val(S_DATA, 32'd0);

    // Count wrap.
    mtc0(5'd9, 32'hffffffff);
    expect_val(S_COUNT, 32'hffffffff);
    tick(1);
    expect_val(S_COUNT, 32'd0);

    // Asynchronous reset between edges with an interrupt exception pending.
    excepttype_i = 32'h1; current_inst_addr_i = 32'h500;
    #2;
    rst = 1'b0;
    #1;
    expect_val(S_EPC, 32'd0);
    expect_val(S_COUNT, 32'd0);
    expect_val(S_CAUSE, 32'd0);
    expect_val(S_STATUS, 32'h10000000);
    expect_val(S_COMPARE, 32'd0);
    tick(1);
    expect_val(S_EPC, 32'd0);
    expect_val(S_TIMER, 32'd0);

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
